// File: rtl/seq_counter_ctrl_if.sv
// Counter-side bus between the sequencer (master) and the 3-bit loadable
// sequence counter (slave).
interface seq_counter_ctrl_if;
    logic       cnt_load;
    logic [2:0] cnt_data;
    logic       cnt_step;
    logic [2:0] cnt_q;

    modport master (
        output cnt_load,
        output cnt_data,
        output cnt_step,
        input  cnt_q
    );

    modport slave (
        input  cnt_load,
        input  cnt_data,
        input  cnt_step,
        output cnt_q
    );
endinterface

// File: rtl/seq_counter_ctrl.sv
// Sequencer for the 3-bit counter: debounces the three push buttons into
// press events and drives load/step strobes, auto-run, and stop-on-target.
module seq_counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DIV_BASE        = 6250000,
    parameter int PRE_W           = 26
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                key_load_n,
    input  logic                key_step_n,
    input  logic                key_run_n,
    input  logic [2:0]          sw_load,
    input  logic [2:0]          sw_target,
    input  logic                target_en,
    input  logic [1:0]          rate_sel,
    seq_counter_ctrl_if.master  cnt_bus,
    output logic [1:0]          state,
    output logic [7:0]          step_count,
    output logic                match
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] BASE    = PRE_W'(DIV_BASE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } st_e;

    // Key index: 0 = load, 1 = step, 2 = run
    logic [2:0] keys_n;
    logic [2:0] press;

    assign keys_n = {key_run_n, key_step_n, key_load_n};

    for (genvar k = 0; k < 3; k++) begin : g_key
        logic            s1_q;
        logic            s2_q;
        logic            lvl_q;
        logic            lvl_d;
        logic            lvl_prev_q;
        logic [DB_W-1:0] cnt_q;
        logic [DB_W-1:0] cnt_d;

        // The stability count restarts whenever the synchronized level agrees
        // with the debounced one, so only an unbroken run of DEBOUNCE_CYCLES
        // differing cycles flips the level.
        always_comb begin
            cnt_d = '0;
            lvl_d = lvl_q;
            if (s2_q != lvl_q) begin
                if (cnt_q == DB_LAST) begin
                    lvl_d = s2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s1_q       <= 1'b1;
                s2_q       <= 1'b1;
                lvl_q      <= 1'b1;
                lvl_prev_q <= 1'b1;
                cnt_q      <= '0;
            end else begin
                s1_q       <= keys_n[k];
                s2_q       <= s1_q;
                lvl_q      <= lvl_d;
                lvl_prev_q <= lvl_q;
                cnt_q      <= cnt_d;
            end
        end

        assign press[k] = lvl_prev_q & ~lvl_q;
    end

    logic ev_load;
    logic ev_step;
    logic ev_run;

    assign ev_load = press[0];
    assign ev_step = press[1];
    assign ev_run  = press[2];

    st_e              state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] period_q, period_d;
    logic [PRE_W-1:0] period_sel;
    logic [7:0]       sc_q, sc_d;
    logic             match_q, match_d;
    logic             load_q, load_d;
    logic [2:0]       data_q, data_d;
    logic             step_q, step_d;
    logic             run_step_q, run_step_d;
    logic             chk_q, chk_d;
    logic             hit;

    assign period_sel = BASE << rate_sel;

    // chk_q marks the cycle in which cnt_q already reflects a step issued
    // from RUN; a hit there stops the run ahead of any terminal count.
    assign hit = chk_q && target_en && (cnt_bus.cnt_q == sw_target);

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        period_d   = period_q;
        sc_d       = sc_q;
        match_d    = match_q;
        load_d     = 1'b0;
        data_d     = data_q;
        step_d     = 1'b0;
        run_step_d = 1'b0;
        chk_d      = run_step_q;

        if (ev_load) begin
            load_d  = 1'b1;
            data_d  = sw_load;
            sc_d    = '0;
            pre_d   = '0;
            match_d = 1'b0;
            chk_d   = 1'b0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (ev_run) begin
                        state_d  = ST_RUN;
                        pre_d    = '0;
                        period_d = period_sel;
                    end else if (ev_step) begin
                        step_d = 1'b1;
                        sc_d   = sc_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (ev_run) begin
                        state_d = ST_PAUSE;
                    end else if (hit) begin
                        state_d = ST_DONE;
                        match_d = 1'b1;
                    end else if (pre_q == period_q - 1'b1) begin
                        step_d     = 1'b1;
                        run_step_d = 1'b1;
                        sc_d       = sc_q + 8'd1;
                        pre_d      = '0;
                        period_d   = period_sel;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (ev_run) begin
                        state_d = ST_RUN;
                    end else if (ev_step) begin
                        step_d = 1'b1;
                        sc_d   = sc_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (ev_run) begin
                        state_d  = ST_RUN;
                        pre_d    = '0;
                        period_d = period_sel;
                        match_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            period_q   <= BASE;
            sc_q       <= '0;
            match_q    <= 1'b0;
            load_q     <= 1'b0;
            data_q     <= '0;
            step_q     <= 1'b0;
            run_step_q <= 1'b0;
            chk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            period_q   <= period_d;
            sc_q       <= sc_d;
            match_q    <= match_d;
            load_q     <= load_d;
            data_q     <= data_d;
            step_q     <= step_d;
            run_step_q <= run_step_d;
            chk_q      <= chk_d;
        end
    end

    assign cnt_bus.cnt_load = load_q;
    assign cnt_bus.cnt_data = data_q;
    assign cnt_bus.cnt_step = step_q;
    assign state            = state_q;
    assign step_count       = sc_q;
    assign match            = match_q;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed bench for seq_counter_ctrl: table-driven key presses plus
// hand-timed sequences for auto-run, pause/resume, target stop and reset.
module tb_seq_counter_ctrl;

    localparam int DB   = 4;
    localparam int DIVB = 8;
    localparam int PW   = 26;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       key_load_n, key_step_n, key_run_n;
    logic [2:0] sw_load, sw_target;
    logic       target_en;
    logic [1:0] rate_sel;
    logic [1:0] state;
    logic [7:0] step_count;
    logic       match;

    always #5 clk = ~clk;

    seq_counter_ctrl_if bus ();

    seq_counter_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DIV_BASE       (DIVB),
        .PRE_W          (PW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_load_n(key_load_n),
        .key_step_n(key_step_n),
        .key_run_n (key_run_n),
        .sw_load   (sw_load),
        .sw_target (sw_target),
        .target_en (target_en),
        .rate_sel  (rate_sel),
        .cnt_bus   (bus.master),
        .state     (state),
        .step_count(step_count),
        .match     (match)
    );

    // Counter model: +1 per step, modulo 8
    logic [2:0] cnt_m;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          cnt_m <= 3'd0;
        else if (bus.cnt_load) cnt_m <= bus.cnt_data;
        else if (bus.cnt_step) cnt_m <= cnt_m + 3'd1;
    end
    assign bus.cnt_q = cnt_m;

    int         cyc = 0;
    int         n_load = 0;
    int         n_step = 0;
    int         n_both = 0;
    int         last_step_cyc = 0;
    logic [2:0] last_data = 3'd0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.cnt_load) begin
            n_load++;
            last_data = bus.cnt_data;
        end
        if (bus.cnt_step) begin
            n_step++;
            last_step_cyc = cyc;
        end
        if (bus.cnt_load && bus.cnt_step) n_both++;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic key_down(input int key);
        case (key)
            0: key_load_n = 1'b0;
            1: key_step_n = 1'b0;
            default: key_run_n = 1'b0;
        endcase
    endtask

    task automatic key_up(input int key);
        case (key)
            0: key_load_n = 1'b1;
            1: key_step_n = 1'b1;
            default: key_run_n = 1'b1;
        endcase
    endtask

    task automatic press(input int key, input int hold);
        @(negedge clk);
        key_down(key);
        repeat (hold) @(negedge clk);
        key_up(key);
    endtask

    task automatic wait_step(input string name, input int budget);
        int  n0;
        bit  ok;
        n0 = n_step;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_step != n0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_state(input string name, input logic [1:0] exp, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state == exp) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, ok, 1);
    endtask

    typedef struct {
        int         key;
        int         hold;
        logic [2:0] swl;
        int         exp_loads;
        int         exp_steps;
        logic [2:0] exp_data;
        logic [1:0] exp_state;
        logic [7:0] exp_sc;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0, s0, t_entry, t_prev, t_p, t_r;

        tbl[0] = '{0, 10, 3'd5, 1, 0, 3'd5, 2'd0, 8'd0};
        tbl[1] = '{1,  3, 3'd5, 0, 0, 3'd5, 2'd0, 8'd0};
        tbl[2] = '{1,  8, 3'd5, 0, 1, 3'd5, 2'd0, 8'd1};
        tbl[3] = '{1,  8, 3'd5, 0, 1, 3'd5, 2'd0, 8'd2};
        tbl[4] = '{1,  8, 3'd5, 0, 1, 3'd5, 2'd0, 8'd3};
        tbl[5] = '{1,  4, 3'd5, 0, 1, 3'd5, 2'd0, 8'd4};
        tbl[6] = '{0,  3, 3'd2, 0, 0, 3'd5, 2'd0, 8'd4};
        tbl[7] = '{0,  4, 3'd0, 1, 0, 3'd0, 2'd0, 8'd0};

        reset_n    = 1'b0;
        key_load_n = 1'b1;
        key_step_n = 1'b1;
        key_run_n  = 1'b1;
        sw_load    = 3'd0;
        sw_target  = 3'd0;
        target_en  = 1'b0;
        rate_sel   = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst state", state, 0);
        chk("rst step_count", step_count, 0);
        chk("rst match", match, 0);
        chk("rst cnt_load", bus.cnt_load, 0);
        chk("rst cnt_step", bus.cnt_step, 0);
        chk("rst cnt_data", bus.cnt_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            l0 = n_load;
            s0 = n_step;
            sw_load = tbl[i].swl;
            press(tbl[i].key, tbl[i].hold);
            repeat (14) @(negedge clk);
            chk($sformatf("vec%0d loads", i), n_load - l0, tbl[i].exp_loads);
            chk($sformatf("vec%0d steps", i), n_step - s0, tbl[i].exp_steps);
            chk($sformatf("vec%0d cnt_data", i), last_data, tbl[i].exp_data);
            chk($sformatf("vec%0d state", i), state, tbl[i].exp_state);
            chk($sformatf("vec%0d step_count", i), step_count, tbl[i].exp_sc);
        end

        // Auto-run at 32 cycles, rate change lands after the current period
        rate_sel = 2'd2;
        @(negedge clk);
        key_down(2);
        wait_state("run entry", 2'd1, 30);
        t_entry = cyc;
        key_up(2);
        wait_step("run step1 seen", 64);
        chk("run first period", last_step_cyc - t_entry, 32);
        t_prev = last_step_cyc;
        repeat (10) @(negedge clk);
        rate_sel = 2'd0;
        wait_step("run step2 seen", 64);
        chk("period before rate change", last_step_cyc - t_prev, 32);
        t_prev = last_step_cyc;
        wait_step("run step3 seen", 64);
        chk("period after rate change", last_step_cyc - t_prev, 8);
        t_prev = last_step_cyc;
        wait_step("run step4 seen", 64);
        chk("period 8 again", last_step_cyc - t_prev, 8);

        // Pause with the prescaler at 5, step in pause, resume
        wait_step("run step5 seen", 64);
        repeat (6) @(negedge clk);
        @(negedge clk);
        key_down(2);
        wait_state("pause entry", 2'd2, 30);
        t_p = cyc;
        chk("pause after step", t_p - last_step_cyc, 6);
        key_up(2);
        s0 = n_step;
        repeat (100) @(negedge clk);
        chk("pause no steps", n_step - s0, 0);
        chk("pause state held", state, 2);
        press(1, 8);
        repeat (14) @(negedge clk);
        chk("pause step count", n_step - s0, 1);
        chk("pause step_count", step_count, 7);
        chk("pause state after step", state, 2);
        @(negedge clk);
        key_down(2);
        wait_state("resume entry", 2'd1, 30);
        t_r = cyc;
        key_up(2);
        wait_step("resume step seen", 30);
        chk("resume step delay", last_step_cyc - t_r, 3);

        // Stop on target 3 starting from a load of 1
        sw_load = 3'd1;
        press(0, 8);
        repeat (14) @(negedge clk);
        chk("tgt load state", state, 0);
        chk("tgt load cnt", cnt_m, 1);
        chk("tgt load step_count", step_count, 0);
        sw_target = 3'd3;
        target_en = 1'b1;
        rate_sel  = 2'd0;
        @(negedge clk);
        key_down(2);
        wait_state("tgt run entry", 2'd1, 30);
        key_up(2);
        wait_step("tgt step1 seen", 30);
        repeat (2) @(negedge clk);
        chk("tgt no done at 2", state, 1);
        wait_step("tgt step2 seen", 30);
        chk("tgt cnt before", cnt_m, 2);
        @(negedge clk);
        chk("tgt cnt reaches 3", cnt_m, 3);
        chk("tgt state one cycle", state, 1);
        @(negedge clk);
        chk("tgt done state", state, 3);
        chk("tgt match", match, 1);
        s0 = n_step;
        repeat (40) @(negedge clk);
        chk("done no steps", n_step - s0, 0);
        chk("done state held", state, 3);
        @(negedge clk);
        key_down(2);
        wait_state("done rerun", 2'd1, 30);
        key_up(2);
        chk("rerun match clear", match, 0);

        // Load and step in the same event cycle
        target_en = 1'b0;
        press(0, 8);
        repeat (14) @(negedge clk);
        chk("pre dual state", state, 0);
        sw_load = 3'd6;
        l0 = n_load;
        s0 = n_step;
        @(negedge clk);
        key_down(0);
        key_down(1);
        repeat (10) @(negedge clk);
        key_up(0);
        key_up(1);
        repeat (14) @(negedge clk);
        chk("dual loads", n_load - l0, 1);
        chk("dual steps", n_step - s0, 0);
        chk("dual cnt_data", last_data, 6);
        chk("dual step_count", step_count, 0);

        // step_count wraps 255 -> 0
        s0 = n_step;
        for (int i = 0; i < 260; i++) begin
            press(1, 6);
            repeat (7) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("wrap steps issued", n_step - s0, 260);
        chk("wrap step_count", step_count, 4);

        // Asynchronous reset during RUN
        @(negedge clk);
        key_down(2);
        wait_state("rst run entry", 2'd1, 30);
        key_up(2);
        repeat (3) @(negedge clk);
        chk("pre-reset step_count", step_count, 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst state", state, 0);
        chk("async rst step_count", step_count, 0);
        chk("async rst match", match, 0);
        chk("async rst cnt_load", bus.cnt_load, 0);
        chk("async rst cnt_step", bus.cnt_step, 0);
        chk("async rst cnt_data", bus.cnt_data, 0);
        chk("load/step exclusive", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
